// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared state encodings, HALT word and parameter defaults for the instruction loader
package instruction_loader_pkg;

  localparam int BITS_FOR_STATE_COUNTER_INSTRUCTION_LOADER = 3;

  typedef enum logic [BITS_FOR_STATE_COUNTER_INSTRUCTION_LOADER-1:0] {
    ST_IDLE    = 3'd0,
    ST_RECEIVE = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } loader_state_t;

  // Same encoding the instruction memory uses to recognise end of program.
  localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;

  localparam int DEFAULT_WORD_SIZE_IN_BYTES = 4;
  localparam int DEFAULT_MEM_SIZE_IN_WORDS  = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES     = 1000000;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// rtl/instruction_loader_word_assembler.sv - big-endian byte-to-word shift register with wrapping byte counter
// o_partial exists only when INSTRUCTION_LOADER_TIMEOUT_EN is defined.
module word_assembler #(
  parameter int WORD_SIZE_IN_BYTES = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clear,
  input  logic                          i_shift,
  input  logic [7:0]                    i_data,
  output logic [8*WORD_SIZE_IN_BYTES-1:0] o_word,
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  output logic                          o_partial,
`endif
  output logic                          o_word_ready
);

  localparam int W   = 8 * WORD_SIZE_IN_BYTES;
  localparam int BCW = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;

  logic [W-1:0]   shreg;
  logic [BCW-1:0] byte_count;
  logic           last_byte;

  assign last_byte = (byte_count == BCW'(WORD_SIZE_IN_BYTES - 1));
  // The completed word is presented combinationally so the loader can register it on the completing edge.
  assign o_word       = (shreg << 8) | W'(i_data);
  assign o_word_ready = i_shift && last_byte;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  assign o_partial    = (byte_count != '0);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg      <= '0;
      byte_count <= '0;
    end else if (i_clear) begin
      shreg      <= '0;
      byte_count <= '0;
    end else if (i_shift) begin
      shreg      <= o_word;
      byte_count <= last_byte ? '0 : byte_count + BCW'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads UART program bytes into instruction memory until HALT is written
// Optional inter-byte timeout: define INSTRUCTION_LOADER_TIMEOUT_EN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
  parameter int MEM_SIZE_IN_WORDS  = DEFAULT_MEM_SIZE_IN_WORDS,
  parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_start,
  input  logic                                   i_rx_valid,
  input  logic [7:0]                             i_rx_data,
  input  logic                                   i_mem_full,
  output logic                                   o_instruction_write,
  output logic [8*WORD_SIZE_IN_BYTES-1:0]        o_instruction,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_error,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0] o_word_count
);

  localparam int W  = 8 * WORD_SIZE_IN_BYTES;
  localparam int CW = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam logic [W-1:0] HALT_WORD = W'(INSTRUCTION_HALT);

  loader_state_t state;
  logic          clear;
  logic          shift;
  logic          word_ready;
  logic [W-1:0]  word;
  logic          timed_out;

  assign clear = (state == ST_IDLE) || (i_start && (state == ST_DONE || state == ST_ERROR));
  // Bytes are accepted in WRITE too, so a byte arriving right after a completed word is kept.
  assign shift = i_rx_valid && (state == ST_RECEIVE || state == ST_WRITE);

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idle_count;
  logic          partial;

  assign timed_out = (state == ST_RECEIVE) && partial && !i_rx_valid &&
                     (idle_count == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      idle_count <= '0;
    else if (state != ST_RECEIVE || i_rx_valid || !partial)
      idle_count <= '0;
    else if (!timed_out)
      idle_count <= idle_count + TW'(1);
  end
`else
  assign timed_out = 1'b0;
`endif

  word_assembler #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
  ) u_word_assembler (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (clear),
    .i_shift     (shift),
    .i_data      (i_rx_data),
    .o_word      (word),
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    .o_partial   (partial),
`endif
    .o_word_ready(word_ready)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state               <= ST_IDLE;
      o_instruction_write <= 1'b0;
      o_instruction       <= '0;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_error             <= 1'b0;
      o_word_count        <= '0;
    end else begin
      o_instruction_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_word_count <= '0;
          if (i_start) begin
            state  <= ST_RECEIVE;
            o_busy <= 1'b1;
          end
        end
        ST_RECEIVE: begin
          if (word_ready) begin
            // A full memory suppresses the strobe; WRITE then sees no strobe and aborts.
            state               <= ST_WRITE;
            o_instruction_write <= !i_mem_full;
            if (!i_mem_full)
              o_instruction <= word;
          end else if (timed_out) begin
            state   <= ST_ERROR;
            o_busy  <= 1'b0;
            o_error <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!o_instruction_write) begin
            state   <= ST_ERROR;
            o_busy  <= 1'b0;
            o_error <= 1'b1;
          end else begin
            if (o_word_count != CW'(MEM_SIZE_IN_WORDS))
              o_word_count <= o_word_count + CW'(1);
            if (o_instruction == HALT_WORD) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state <= ST_RECEIVE;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (i_start) begin
            state        <= ST_RECEIVE;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader (table vectors plus strobe scoreboard)
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_full = 1'b0;
  logic        instr_write;
  logic [31:0] instr;
  logic        busy, done, error;
  logic [6:0]  word_count;

  int checks = 0;
  int failures = 0;
  int strobe_count = 0;
  logic prev_write = 1'b0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  instruction_loader #(
    .WORD_SIZE_IN_BYTES(4),
    .MEM_SIZE_IN_WORDS (64),
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    .TIMEOUT_CYCLES    (16)
`else
    .TIMEOUT_CYCLES    (1000000)
`endif
  ) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_start            (start),
    .i_rx_valid         (rx_valid),
    .i_rx_data          (rx_data),
    .i_mem_full         (mem_full),
    .o_instruction_write(instr_write),
    .o_instruction      (instr),
    .o_busy             (busy),
    .o_done             (done),
    .o_error            (error),
    .o_word_count       (word_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard: every strobe pops the next expected word and must last one cycle.
  always @(negedge clk) begin
    if (!rst && instr_write) begin
      strobe_count++;
      check("strobe_single_cycle", {31'd0, prev_write}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got %h expected no strobe", instr);
      end else begin
        check("strobe_word", instr, sb_q.pop_front());
      end
    end
    prev_write = rst ? 1'b0 : instr_write;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0][7:0] bytes;
    logic [31:0]     expected;
  } vec_t;

  vec_t vecs[3];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [3:0][7:0] bytes);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = bytes[i];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int s0;
    logic [3:0][7:0] w;

    vecs[0] = '{bytes: {8'h20, 8'h08, 8'h00, 8'h05}, expected: 32'h2008_0005};
    vecs[1] = '{bytes: {8'h00, 8'h00, 8'h00, 8'h00}, expected: 32'h0000_0000};
    vecs[2] = '{bytes: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, expected: 32'hFFFF_FFFF};

    idle(2);
    check("reset_write", {31'd0, instr_write}, 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_count", {25'd0, word_count}, 32'd0);
    rst = 1'b0;

    // Pass 0 gapped bytes; pass 1 (after restart) back-to-back, so a byte lands in every WRITE cycle.
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_done_clear", {31'd0, done}, 32'd0);
      check("start_count_clear", {25'd0, word_count}, 32'd0);
      s0 = strobe_count;
      for (int v = 0; v < 3; v++) begin
        sb_q.push_back(vecs[v].expected);
        if (pass == 0) begin
          for (int b = 3; b >= 0; b--) send_byte(vecs[v].bytes[b]);
        end else begin
          send_burst(vecs[v].bytes);
        end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      wait_done();
      check("load_count", {25'd0, word_count}, 32'd3);
      check("load_strobes", strobe_count - s0, 32'd3);
      check("load_busy_low", {31'd0, busy}, 32'd0);
      check("load_queue_empty", sb_q.size(), 32'd0);
    end

    // Bytes after DONE are ignored.
    send_byte(8'h12);
    idle(3);
    check("done_ignores_rx", {25'd0, word_count}, 32'd3);

    // Full memory on the completing byte aborts without a strobe.
    pulse_start();
    sb_q.push_back(32'hA5A5_A5A5);
    for (int b = 0; b < 4; b++) send_byte(8'hA5);
    idle(2);
    s0 = strobe_count;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    mem_full = 1'b1;
    send_byte(8'h04);
    idle(3);
    mem_full = 1'b0;
    check("full_no_strobe", strobe_count - s0, 32'd0);
    check("full_error", {31'd0, error}, 32'd1);
    check("full_count_kept", {25'd0, word_count}, 32'd1);
    check("full_busy_low", {31'd0, busy}, 32'd0);
    check("full_instr_held", instr, 32'hA5A5_A5A5);

    // Reset in the middle of a word.
    pulse_start();
    check("restart_error_clear", {31'd0, error}, 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    check("midreset_instr", instr, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("midreset_write", {31'd0, instr_write}, 32'd0);
    check("midreset_count", {25'd0, word_count}, 32'd0);
    check("midreset_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    pulse_start();
    s0 = strobe_count;
    w = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sb_q.push_back(32'hDEAD_BEEF);
    for (int b = 3; b >= 0; b--) send_byte(w[b]);
    idle(3);
    check("postreset_one_strobe", strobe_count - s0, 32'd1);
    check("postreset_count", {25'd0, word_count}, 32'd1);
    check("postreset_busy", {31'd0, busy}, 32'd1);

    // Partial word followed by silence.
    s0 = strobe_count;
    send_byte(8'h33);
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    idle(20);
    check("timeout_error", {31'd0, error}, 32'd1);
    check("timeout_busy_low", {31'd0, busy}, 32'd0);
`else
    idle(1000);
    check("no_timeout_error", {31'd0, error}, 32'd0);
    check("no_timeout_busy", {31'd0, busy}, 32'd1);
`endif
    check("timeout_no_strobe", strobe_count - s0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
